// File: rtl/troco_pkg.sv
// Shared definitions for the change dispenser (maq_troco): FSM state
// encoding, coin values and one-hot coin request codes.
package troco_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        ESCOLHE = 2'b01,
        ENTREGA = 2'b10,
        FIM     = 2'b11
    } estado_t;

    localparam int unsigned V5  = 5;
    localparam int unsigned V10 = 10;
    localparam int unsigned V20 = 20;

    localparam logic [2:0] M0  = 3'b000;
    localparam logic [2:0] M5  = 3'b001;
    localparam logic [2:0] M10 = 3'b010;
    localparam logic [2:0] M20 = 3'b100;

    // Face value of a one-hot coin code; anything not one-hot is worth nothing.
    function automatic int unsigned valor_moeda(input logic [2:0] m);
        case (m)
            M5:      valor_moeda = V5;
            M10:     valor_moeda = V10;
            M20:     valor_moeda = V20;
            default: valor_moeda = 0;
        endcase
    endfunction

endpackage

// File: rtl/maq_troco_if.sv
// Bus between the sale path / coin hopper and the change dispenser.
// master: the side that requests change and acknowledges coins.
// slave : the dispenser itself.
interface maq_troco_if #(
    parameter int WIDTH = 7
);
    logic             start;
    logic [WIDTH-1:0] valor;
    logic             ack;
    logic             repoe;
    logic             d5;
    logic             d10;
    logic             d20;
    logic             busy;
    logic             done;
    logic             falta;

    modport master (
        output start, valor, ack, repoe,
        input  d5, d10, d20, busy, done, falta
    );

    modport slave (
        input  start, valor, ack, repoe,
        output d5, d10, d20, busy, done, falta
    );
endinterface

// File: rtl/maq_troco_estoque.sv
// Stock counter for one coin denomination: reloads to MAX on refill,
// counts down once per coin delivered, and flags whether any coin is left.
module estoque #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic res,
    input  logic repoe,
    input  logic dec,
    output logic nz
);
    logic [W-1:0] cnt;

    // Refill wins over a decrement on the same edge; never wrap below zero.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt <= W'(MAX);
        end else if (repoe) begin
            cnt <= W'(MAX);
        end else if (dec && nz) begin
            cnt <= cnt - W'(1);
        end
    end

    assign nz = (cnt != '0);
endmodule

// File: rtl/maq_troco.sv
// Change dispenser: takes the change amount at the end of a sale and pays
// it out one coin at a time (20, 10, 5, largest first) to the hopper with
// a request/acknowledge handshake per coin.
// Build option TROCO_ESTOQUE_EN: enables per-denomination stock counters,
// the repoe refill input and the falta (change incomplete) flag. Without
// it every denomination is always available and falta stays low.
module maq_troco
    import troco_pkg::*;
#(
    parameter int WIDTH       = 7,
    parameter int ESTOQUE_W   = 4,
    parameter int ESTOQUE_MAX = 15
) (
    input logic        clk,
    input logic        res,
    maq_troco_if.slave bus
);
    estado_t          estado, estado_nxt;
    logic [WIDTH-1:0] restante, restante_nxt;
    logic [2:0]       moeda, moeda_nxt;
    logic [2:0]       disp;

    localparam logic [WIDTH-1:0] C5  = WIDTH'(V5);
    localparam logic [WIDTH-1:0] C10 = WIDTH'(V10);
    localparam logic [WIDTH-1:0] C20 = WIDTH'(V20);

    // Coin value at the width of the remainder register.
    function automatic logic [WIDTH-1:0] valor_c(input logic [2:0] m);
        valor_c = WIDTH'(valor_moeda(m));
    endfunction

`ifdef TROCO_ESTOQUE_EN
    logic       falta_q, falta_nxt;
    logic [2:0] dec;

    // One stock counter per denomination, bit order matching the coin code.
    for (genvar i = 0; i < 3; i++) begin : g_estoque
        estoque #(
            .W   (ESTOQUE_W),
            .MAX (ESTOQUE_MAX)
        ) u_estoque (
            .clk   (clk),
            .res   (res),
            .repoe (bus.repoe),
            .dec   (dec[i]),
            .nz    (disp[i])
        );
    end
`else
    // Without stock tracking every coin is always on hand and refill is moot.
    logic unused_repoe;
    assign unused_repoe = bus.repoe;
    assign disp         = 3'b111;
`endif

    // Next-state and datapath decisions for the payout sequence.
    always_comb begin
        estado_nxt   = estado;
        restante_nxt = restante;
        moeda_nxt    = moeda;
`ifdef TROCO_ESTOQUE_EN
        falta_nxt    = falta_q;
        dec          = 3'b000;
`endif
        case (estado)
            OCIOSO: begin
                if (bus.start) begin
                    restante_nxt = bus.valor;
`ifdef TROCO_ESTOQUE_EN
                    falta_nxt    = 1'b0;
`endif
                    estado_nxt   = ESCOLHE;
                end
            end
            ESCOLHE: begin
                // A remainder of 1-4 cannot be paid and is dropped silently.
                if (restante < C5) begin
                    estado_nxt = FIM;
                end else if (restante >= C20 && disp[2]) begin
                    moeda_nxt  = M20;
                    estado_nxt = ENTREGA;
                end else if (restante >= C10 && disp[1]) begin
                    moeda_nxt  = M10;
                    estado_nxt = ENTREGA;
                end else if (disp[0]) begin
                    moeda_nxt  = M5;
                    estado_nxt = ENTREGA;
                end else begin
`ifdef TROCO_ESTOQUE_EN
                    falta_nxt  = 1'b1;
`endif
                    estado_nxt = FIM;
                end
            end
            ENTREGA: begin
                // The selection rule never picks a coin larger than the remainder.
                if (bus.ack) begin
                    restante_nxt = restante - valor_c(moeda);
`ifdef TROCO_ESTOQUE_EN
                    dec          = moeda;
`endif
                    moeda_nxt    = M0;
                    estado_nxt   = ESCOLHE;
                end
            end
            FIM: begin
                estado_nxt = OCIOSO;
            end
            default: begin
                estado_nxt = OCIOSO;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_nxt;
        end
    end

    // Remainder and coin-request registers; reset drops any in-flight coin.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            restante <= '0;
            moeda    <= M0;
        end else begin
            restante <= restante_nxt;
            moeda    <= moeda_nxt;
        end
    end

`ifdef TROCO_ESTOQUE_EN
    // Sticky shortage flag, cleared only by the next accepted start.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            falta_q <= 1'b0;
        end else begin
            falta_q <= falta_nxt;
        end
    end

    assign bus.falta = falta_q;
`else
    assign bus.falta = 1'b0;
`endif

    assign bus.d5   = moeda[0];
    assign bus.d10  = moeda[1];
    assign bus.d20  = moeda[2];
    assign bus.busy = (estado != OCIOSO);
    assign bus.done = (estado == FIM);

endmodule

// File: tb/tb_maq_troco.sv
// Bench for maq_troco: directed payouts plus randomized ones, checked
// against a greedy coin model that tracks the remainder and the stocks.
module tb_maq_troco;
    localparam int WIDTH = 7;
    localparam int EMAX  = 15;
`ifdef TROCO_ESTOQUE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk;
    logic res;
    int   n_chk = 0;
    int   n_err = 0;
    int   stk[3];

    maq_troco_if #(.WIDTH(WIDTH)) bus ();

    maq_troco #(
        .WIDTH       (WIDTH),
        .ESTOQUE_W   (4),
        .ESTOQUE_MAX (EMAX)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Greedy choice: largest coin not above the remainder that is in stock.
    // 0 = nothing to pay, -1 = shortage; otherwise one-hot {d20,d10,d5}.
    function automatic int pick(input int r);
        if (r < 5) return 0;
        if (r >= 20 && (!EN || stk[2] > 0)) return 4;
        if (r >= 10 && (!EN || stk[1] > 0)) return 2;
        if (!EN || stk[0] > 0) return 1;
        return -1;
    endfunction

    function automatic int val(input int code);
        case (code)
            4:       return 20;
            2:       return 10;
            1:       return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int idx(input int code);
        case (code)
            4:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic encher();
        for (int i = 0; i < 3; i++) stk[i] = EMAX;
    endtask

    task automatic refill();
        @(negedge clk);
        bus.repoe = 1'b1;
        @(negedge clk);
        bus.repoe = 1'b0;
        if (EN) encher();
    endtask

    // One complete payout. Each coin is acknowledged after a random wait in
    // [dmin,dmax] cycles; optionally a stray start and a refill on a 5-coin ack.
    task automatic payout(input int v, input int dmin, input int dmax,
                          input bit ack_sempre, input bit start_extra,
                          input bit repoe_d5);
        int rest, n, req, prev_req, cur, hold, dly, sum_d, ncoins, g, exp_falta;
        bit fim, acked, ack_now;
        rest = v; n = 0; prev_req = 0; cur = 0; hold = 0; dly = 0;
        sum_d = 0; ncoins = 0; g = 0; exp_falta = 0; fim = 0; acked = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.valor = WIDTH'(v);
        bus.ack   = ack_sempre;
        @(negedge clk);
        n = 1;
        check("falta_clr", bus.falta, 0);
        while (!fim && n < 400) begin
            req = {bus.d20, bus.d10, bus.d5};
            bus.start = 1'b0;
            bus.repoe = 1'b0;
            bus.ack   = ack_sempre;
            ack_now   = 1'b0;
            if (bus.done) begin
                fim = 1'b1;
                g = pick(rest);
                exp_falta = (g < 0) ? 1 : 0;
                check("done_ciclos", n, 2 + 2 * ncoins + sum_d);
                check("fim_valido", (g <= 0) ? 1 : 0, 1);
                check("falta", bus.falta, exp_falta);
                check("req_no_fim", req, 0);
            end else begin
                check("busy", bus.busy, 1);
                if (acked) begin
                    check("queda", req, 0);
                end else if (req != 0) begin
                    if (prev_req == 0) begin
                        g = pick(rest);
                        check("moeda", req, g);
                        cur  = req;
                        hold = 0;
                        dly  = $urandom_range(dmax, dmin);
                    end else begin
                        check("req_estavel", req, cur);
                    end
                end else if (prev_req != 0) begin
                    check("queda_cedo", req, cur);
                end
                if (!acked && req != 0) begin
                    hold++;
                    if (hold > dly) begin
                        ack_now = 1'b1;
                        bus.ack = 1'b1;
                        rest   -= val(cur);
                        ncoins++;
                        sum_d  += dly;
                        if (repoe_d5 && cur == 1) begin
                            bus.repoe = 1'b1;
                            if (EN) encher();
                        end else if (EN) begin
                            stk[idx(cur)]--;
                        end
                    end
                end
                if (start_extra && n == 3) begin
                    bus.start = 1'b1;
                    bus.valor = WIDTH'($urandom);
                end
            end
            acked    = ack_now;
            prev_req = req;
            @(negedge clk);
            n++;
        end
        check("terminou", fim, 1);
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        bus.repoe = 1'b0;
        check("done_pulso", bus.done, 0);
        check("ocioso", bus.busy, 0);
        check("falta_retida", bus.falta, exp_falta);
    endtask

    // Reset while a 10-coin is being requested: request and busy drop at once.
    task automatic reset_meio();
        int n;
        n = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.valor = WIDTH'(15);
        bus.ack   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.d10 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("d10_visto", bus.d10, 1);
        #2 res = 1'b0;
        #1;
        check("rst_d10", bus.d10, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_falta", bus.falta, 0);
        @(negedge clk);
        res = 1'b1;
        if (EN) encher();
    endtask

    initial begin
        res       = 1'b1;
        bus.start = 1'b0;
        bus.valor = '0;
        bus.ack   = 1'b0;
        bus.repoe = 1'b0;
        encher();
        #2 res = 1'b0;
        #1;
        check("rst_reqs", {bus.d20, bus.d10, bus.d5}, 0);
        check("rst_busy0", bus.busy, 0);
        check("rst_done0", bus.done, 0);
        check("rst_falta0", bus.falta, 0);
        repeat (2) @(negedge clk);
        res = 1'b1;

        payout(35, 0, 0, 1'b1, 1'b0, 1'b0);
        payout(40, 3, 3, 1'b0, 1'b0, 1'b0);
        payout(7, 0, 0, 1'b1, 1'b0, 1'b0);
        payout(3, 0, 0, 1'b1, 1'b0, 1'b0);
        reset_meio();
        payout(25, 0, 1, 1'b0, 1'b0, 1'b0);
        payout(35, 0, 2, 1'b0, 1'b1, 1'b0);

        if (EN) begin
            payout(120, 0, 0, 1'b0, 1'b0, 1'b0);
            payout(120, 0, 0, 1'b0, 1'b0, 1'b0);
            payout(60, 0, 0, 1'b0, 1'b0, 1'b0);
            payout(120, 0, 0, 1'b0, 1'b0, 1'b0);
            payout(20, 0, 0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 14; i++) payout(5, 0, 0, 1'b0, 1'b0, 1'b0);
            payout(40, 0, 1, 1'b0, 1'b0, 1'b0);
            refill();
            payout(5, 0, 0, 1'b0, 1'b0, 1'b1);
            payout(75, 0, 0, 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            if (i % 6 == 5) refill();
            payout($urandom_range(127, 0), 0, 3, 1'b0,
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
